// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue and held in a pending register until the latency expires.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0]    C_MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0]    C_DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] C_ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ONES      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_MIN       = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_keep;
    logic             r_busy;
    logic             r_done;

    logic [2*WIDTH-1:0]      w_a_sx;
    logic [2*WIDTH-1:0]      w_b_sx;
    logic [2*WIDTH-1:0]      w_a_zx;
    logic [2*WIDTH-1:0]      w_b_zx;
    logic [2*WIDTH-1:0]      w_prod_s;
    logic [2*WIDTH-1:0]      w_prod_u;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic [WIDTH-1:0]        w_dvs_s;
    logic [WIDTH-1:0]        w_dvs_u;
    logic signed [WIDTH-1:0] w_quo_s;
    logic signed [WIDTH-1:0] w_rem_s;
    logic [WIDTH-1:0]        w_quo_u;
    logic [WIDTH-1:0]        w_rem_u;
    logic [WIDTH-1:0]        w_res_hi;
    logic [WIDTH-1:0]        w_res_lo;
    logic                    w_is_md;
    logic                    w_div0;
    logic [CW-1:0]           w_load;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign w_a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign w_b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign w_a_zx   = {C_ZERO, src_a};
    assign w_b_zx   = {C_ZERO, src_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;

    // Divisors are forced to one where the real quotient is special-cased, so the dividers never trap.
    assign w_b_zero = (src_b == C_ZERO);
    assign w_ovf    = (src_a == C_MIN) && (src_b == C_ONES);
    assign w_dvs_s  = (w_b_zero || w_ovf) ? C_ONE : src_b;
    assign w_dvs_u  = w_b_zero ? C_ONE : src_b;
    assign w_quo_s  = $signed(src_a) / $signed(w_dvs_s);
    assign w_rem_s  = $signed(src_a) % $signed(w_dvs_s);
    assign w_quo_u  = src_a / w_dvs_u;
    assign w_rem_u  = src_a % w_dvs_u;

    // Select the result, latency and divide-by-zero flag for the issuing op.
    always_comb begin
        w_res_hi = C_ZERO;
        w_res_lo = C_ZERO;
        w_is_md  = 1'b0;
        w_div0   = 1'b0;
        w_load   = C_MULT_LOAD;
        case (op)
            3'b000: begin
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
                w_is_md  = 1'b1;
            end
            3'b001: begin
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
                w_is_md  = 1'b1;
            end
            3'b010: begin
                if (w_ovf) begin
                    w_res_hi = C_ZERO;
                    w_res_lo = C_MIN;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
                w_is_md = 1'b1;
                w_div0  = w_b_zero;
                w_load  = C_DIV_LOAD;
            end
            3'b011: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
                w_is_md  = 1'b1;
                w_div0   = w_b_zero;
                w_load   = C_DIV_LOAD;
            end
            default: begin
                w_is_md = 1'b0;
            end
        endcase
    end

    // Control FSM, architectural HI/LO and pending result; issues while running are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_hi        <= C_ZERO;
            r_lo        <= C_ZERO;
            r_pend_hi   <= C_ZERO;
            r_pend_lo   <= C_ZERO;
            r_pend_keep <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_is_md) begin
                        r_pend_hi   <= w_res_hi;
                        r_pend_lo   <= w_res_lo;
                        r_pend_keep <= w_div0;
                        r_cnt       <= w_load;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end else if (start && (op == 3'b100)) begin
                        r_hi <= src_a;
                    end else if (start && (op == 3'b101)) begin
                        r_lo <= src_a;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == {CW{1'b0}}) begin
                        if (!r_pend_keep) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end else begin
                            r_hi <= r_hi;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: cycle-accurate reference model plus directed literal checks,
// with a second small instance (WIDTH=8, single-cycle latency).
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        s_start = 1'b0;
    logic [2:0]  s_op = 3'b000;
    logic [7:0]  s_a = 8'h0;
    logic [7:0]  s_b = 8'h0;
    logic        s_busy, s_done;
    logic [7:0]  s_hi, s_lo;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .src_a(s_a), .src_b(s_b),
        .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic using 64-bit integers; keep=1 means HI/LO must stay unchanged.
    function automatic void md_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic keep);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = 32'h0; rl = 32'h0; keep = 1'b0;
        case (o)
            3'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (b == 32'h0) keep = 1'b1;
                else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
            end
            3'd3: begin
                if (b == 32'h0) keep = 1'b1;
                else begin rl = a / b; rh = a % b; end
            end
            default: keep = 1'b1;
        endcase
    endfunction

    logic [31:0] mr_hi, mr_lo;
    logic        mr_keep;
    always @* md_ref(op, src_a, src_b, mr_hi, mr_lo, mr_keep);

    int          cyc = 0;
    int          m_t0 = 0;
    int          m_n = 0;
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, m_phi = 32'h0, m_plo = 32'h0;
    logic        m_pkeep = 1'b0;

    // Model: an issue at the edge ending cycle t0 completes at the edge ending cycle t0+N.
    always @(posedge clk) begin
        if (!reset) begin
            m_active <= 1'b0; m_done <= 1'b0; m_hi <= 32'h0; m_lo <= 32'h0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (cyc == m_t0 + m_n) begin
                    if (!m_pkeep) begin m_hi <= m_phi; m_lo <= m_plo; end
                    m_done <= 1'b1;
                    m_active <= 1'b0;
                end
            end else if (start && op <= 3'd3) begin
                m_active <= 1'b1; m_t0 <= cyc; m_n <= (op < 3'd2) ? MC : DC;
                m_phi <= mr_hi; m_plo <= mr_lo; m_pkeep <= mr_keep;
            end else if (start && op == 3'd4) m_hi <= src_a;
            else if (start && op == 3'd5) m_lo <= src_a;
        end
        cyc <= cyc + 1;
    end

    // Compare process: every cycle once the DUT has been reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'h0, busy}, {63'h0, m_active});
            check("done", {63'h0, done}, {63'h0, m_done});
            check("hi", {32'h0, hi}, {32'h0, m_hi});
            check("lo", {32'h0, lo}, {32'h0, m_lo});
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] eh, input logic [31:0] el);
        int nb = 0;
        logic seen = 1'b0;
        @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, {63'h0, seen}, 64'h1);
        check({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        check({name, "_hi"}, {32'h0, hi}, {32'h0, eh});
        check({name, "_lo"}, {32'h0, lo}, {32'h0, el});
        @(negedge clk);
        check({name, "_done_pulse"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        logic [31:0] ph, pl;
        logic pk;
        // Pin the reference model against hand-computed values.
        md_ref(3'd0, 32'hFFFFFFFE, 32'd3, ph, pl, pk);
        check("ref_mult", {ph, pl}, 64'hFFFFFFFF_FFFFFFFA);
        md_ref(3'd2, 32'h80000000, 32'hFFFFFFFF, ph, pl, pk);
        check("ref_div_ovf", {ph, pl}, 64'h00000000_80000000);
        md_ref(3'd2, 32'hFFFFFFF9, 32'd2, ph, pl, pk);
        check("ref_div_neg", {ph, pl}, 64'hFFFFFFFF_FFFFFFFD);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);

        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h00000001);
        run_op("divu", 3'd3, 32'd7, 32'd2, DC, 32'd1, 32'd3);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000);

        // mthi then mtlo back to back.
        @(negedge clk); start = 1'b1; op = 3'd4; src_a = 32'h12345678;
        @(negedge clk); op = 3'd5; src_a = 32'h0000ABCD;
        check("mthi_hi", {32'h0, hi}, 64'h12345678);
        @(negedge clk); start = 1'b0;
        check("mtlo_lo", {32'h0, lo}, 64'h0000ABCD);
        check("mtx_busy", {63'h0, busy}, 64'h0);
        run_op("div0", 3'd2, 32'd5, 32'd0, DC, 32'h12345678, 32'h0000ABCD);

        // Reserved op is ignored.
        @(negedge clk); start = 1'b1; op = 3'd6; src_a = 32'hDEADBEEF; src_b = 32'd1;
        @(negedge clk); start = 1'b0;
        check("rsv_busy", {63'h0, busy}, 64'h0);
        check("rsv_hi", {32'h0, hi}, 64'h12345678);

        // Issues while busy are dropped.
        @(negedge clk); start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk); op = 3'd5; src_a = 32'h5555;
        @(negedge clk); start = 1'b0;
        check("ign_lo_mid", {32'h0, lo}, 64'h0000ABCD);
        repeat (6) @(negedge clk);
        check("ign_done", {63'h0, done}, 64'h1);
        check("ign_result", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);

        // Reset mid-operation discards the pending result.
        @(negedge clk); start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        repeat (MC) begin
            @(negedge clk);
            check("rst_no_done", {63'h0, done}, 64'h0);
        end

        // Small instance: single-cycle latency, WIDTH=8.
        @(negedge clk); s_start = 1'b1; s_op = 3'd0; s_a = 8'h80; s_b = 8'h02;
        @(negedge clk); s_start = 1'b0;
        check("s_busy", {63'h0, s_busy}, 64'h1);
        check("s_done_early", {63'h0, s_done}, 64'h0);
        @(negedge clk);
        check("s_busy_end", {63'h0, s_busy}, 64'h0);
        check("s_done", {63'h0, s_done}, 64'h1);
        check("s_result", {48'h0, s_hi, s_lo}, 64'hFF00);
        @(negedge clk);
        check("s_done_pulse", {63'h0, s_done}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the E stage of the 5-stage pipeline.
- Executes mult/multu/div/divu over a configurable number of cycles and mthi/mtlo in one cycle.
- Exposes busy so the hazard unit can stall any following MD-class instruction in D/E.
- Generalises the single-cycle ALU path to variable width and variable latency.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=2)
MULT_CYCLES, 5, cycles mult/multu hold busy (>=1)
DIV_CYCLES, 10, cycles div/divu hold busy (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets)
start  input  1  issue strobe, sampled each rising edge
op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved
src_a  input  WIDTH  rs operand, forwarded value from E stage
src_b  input  WIDTH  rt operand, forwarded value from E stage
busy  output  1  operation in flight
done  output  1  one-cycle pulse, new HI/LO visible this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at edge): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Applies even mid-operation; the pending result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, op in {mult,multu,div,divu} at edge T0:
  - Latch the computed result into pending_hi/pending_lo (full result computed from src_a/src_b at T0).
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES) and go to RUN.
- RUN:
  - busy=1 in cycles T0+1 .. T0+N.
  - Counter decrements each edge.
  - At the edge ending cycle T0+N (counter==0): hi<=pending_hi, lo<=pending_lo, busy<=0, done<=1, go to IDLE.
  - done=1 only in cycle T0+N+1.
- mthi/mtlo, IDLE, start=1: hi<=src_a (mthi) or lo<=src_a (mtlo) at the same edge. busy stays 0, done stays 0, other register unchanged.
- start=1 while busy=1: ignored entirely, including mthi/mtlo. The hazard unit guarantees no issue while busy; the unit must still be robust.
- start=1 with reserved op: ignored, no state change.
- hi/lo hold their old values throughout RUN; reads during RUN return pre-operation values.
- Arithmetic:
  - mult: signed WIDTH x WIDTH -> 2*WIDTH; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - multu: same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - Signed overflow (most-negative / -1): lo=most-negative, hi=0.
  - Divide by zero (div or divu): full DIV_CYCLES latency and busy as normal; at completion hi/lo retain their prior values and done still pulses.
- No combinational path from start/op/src to busy/hi/lo; all outputs are registered.
- Counter width is clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Test Plan:
- Reset released, then start mult src_a=0xFFFFFFFE, src_b=3 at T0 (defaults) -> busy=1 cycles T0+1..T0+5; at T0+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle; hi/lo=0 before.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles. divu 7/2 -> lo=3, hi=1 after 10 busy cycles.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x12345678 then mtlo 0xABCD on consecutive cycles -> hi/lo updated on each edge, busy never asserts; div 5/0 afterwards -> busy 10 cycles, done pulses, hi=0x12345678, lo=0xABCD retained.
- Start div at T0; start mult and mtlo at T0+3 (while busy) -> both ignored; completion at T0+11 shows only the div result.
- Start mult, drive reset=0 at T0+2 -> next cycle busy=0, hi=lo=0, no done pulse. Rerun with MULT_CYCLES=1, DIV_CYCLES=1, WIDTH=8: mult 0x80 x 0x02 -> busy one cycle, hi=0xFF, lo=0x00.
